ext_tuner_ctrl: RTL and testbench
=================================

# ext_tuner_ctrl

Parametrised controller for an external automatic antenna tuner (ATU). It is the successor to the fixed ICOM AH-4 sequencer. It sits between the host auto-tune request and the PTT/MOX path. It issues the tuner start signal, tracks the tuner's busy/status line with synchronisation and debounce, and retries on no-response. It reports a result code and gates transmission once tuning ends.

## Interface
Parameters:
- TICK_DIV, 48000 — clk cycles per sequencer tick (1 ms at 48 MHz); legal range 2..131072.
- DELAY_T, 100 — ticks from request to start assertion.
- PULSE_T, 500 — ticks that start is held asserted.
- ACK_T, 1000 — max ticks waiting for status to go active after start is released.
- TUNE_T, 9000 — max ticks status may remain active.
- GAP_T, 200 — ticks between a no-ack failure and the retry.
- RETRIES, 2 — extra start attempts after a no-ack timeout; 0..7.
- DEB_T, 3 — consecutive ticks a synchronised status level must hold before it is accepted; 1..15.
- STATUS_POL, 1 — status level that means "tuning" (1 = high).
- LEVEL_MODE, 0 — 0: start is a timed pulse (PULSE_T). 1: start is held from the DELAY expiry until status is accepted active or the ACK timeout.

Ports:
- clk, in, 1 — single clock.
- rst_n, in, 1 — asynchronous, active-low reset.
- auto_tune, in, 1 — tune request level from host; synchronous to clk.
- atu_status, in, 1 — raw tuner status line; asynchronous.
- mox_in, in, 1 — transmit request.
- atu_start, out, 1 — drive to tuner start/key line.
- mox_out, out, 1 — gated transmit.
- busy, out, 1 — high in every state except IDLE, DONE and FAIL.
- result, out, 2 — 00 none/in progress, 01 tuned OK, 10 no ack after all retries, 11 tune timeout.
- attempt, out, 3 — number of start attempts issued in the current request.

## Operation
- Prescaler: a down-counter reloads to TICK_DIV-1. `tick` is a one-cycle pulse when the counter is 0. The first tick after reset occurs on the first cycle after reset release.
- atu_status passes through a 2-flop synchroniser, then is XNORed with STATUS_POL to give `act`.
- Debounce: `act` is sampled on each tick. The accepted status `st` changes only after DEB_T consecutive tick samples of the new level. `st` resets to 0.
- States: IDLE, DELAY, START, WAIT_ACK, TUNING, GAP, DONE, FAIL. Timer is 16 bits and is loaded with N-1 on entry. A timed state exits on the tick where the timer reads 0; otherwise the timer decrements by 1 per tick.
- All transitions below are evaluated only on tick cycles, except the auto_tune abort.
- IDLE: when auto_tune=1, go to DELAY; clear result, set attempt=0.
- DELAY (DELAY_T): go to START; attempt +1; atu_start=1.
- START, LEVEL_MODE=0 (PULSE_T): at expiry atu_start=0 and go to WAIT_ACK.
- START, LEVEL_MODE=1: pass straight to WAIT_ACK with atu_start still 1.
- WAIT_ACK (ACK_T):
  - If st=1: atu_start=0, go to TUNING.
  - Else on timeout: atu_start=0. If attempt ≤ RETRIES, go to GAP; else result=10 and go to FAIL.
- GAP (GAP_T): go to START; attempt +1; atu_start=1.
- TUNING (TUNE_T):
  - If st=0: result=01, go to DONE.
  - Else on timeout: result=11, go to FAIL.
- DONE and FAIL: hold until auto_tune=0.
- mox_out = mox_in & ~inhibit. inhibit=1 in DONE and FAIL only.
- Abort: auto_tune=0 on any cycle (not only on a tick) forces, on the next edge, state=IDLE, atu_start=0 and inhibit=0. result and attempt keep their last values so the host can read the outcome after dropping the request.
- A new request from IDLE clears result to 00.

## Timing
- Reset values: state IDLE, atu_start 0, busy 0, result 00, attempt 0, st 0, synchroniser 0, timer 0, prescaler 0. mox_out follows mox_in combinationally.
- Status latency: raw edge to `st` change is 2 clk of synchronisation plus DEB_T to DEB_T+1 ticks.
- Request latency (LEVEL_MODE=0): auto_tune rise to atu_start rise is 1 to 2 ticks for IDLE→DELAY, plus DELAY_T ticks. atu_start width is exactly PULSE_T ticks.
- atu_start is registered and never glitches.
- Simultaneous events:
  - In WAIT_ACK, st=1 on the timeout tick counts as ack.
  - In TUNING, st=0 on the timeout tick gives result 01.
  - An abort on a tick cycle overrides any transition.
- A reset asserted mid-sequence drops atu_start asynchronously.

## Test plan
Bench parameters: TICK_DIV=4, DELAY_T=2, PULSE_T=3, ACK_T=5, TUNE_T=8, GAP_T=2, RETRIES=1, DEB_T=2.
- Normal tune: auto_tune=1; drive status high 2 ticks after pulse end, low after 4 ticks. Required: atu_start high for 12 clk, result=01, attempt=1, mox_out=0 while mox_in=1, busy falls at DONE.
- No-ack: status held low. Required: two start pulses separated by GAP, result=10, attempt=2, FAIL, mox_out=0.
- Stuck tuner: status held high after the first pulse. Required: result=11 after 8 ticks in TUNING; no second start pulse.
- Glitch rejection: a 1-tick status pulse during WAIT_ACK. Required: no TUNING entry; retry occurs.
- Abort mid-pulse: auto_tune=0 during START. Required: atu_start=0 and state IDLE on the next clk; mox_out=mox_in. Re-request gives result=00 and attempt restarting at 1.
- Mode and polarity: LEVEL_MODE=1, STATUS_POL=0, status falls 3 ticks after the start rise. Required: atu_start stays high until `st` is accepted, then goes low. Async reset mid-TUNING: all outputs reset immediately.

Source files
------------

// File: rtl/ext_tuner_ctrl.sv
// ext_tuner_ctrl: sequencer for an external automatic antenna tuner.
// Issues the tuner start/key signal after a host request, follows the
// tuner's status line (synchronised and debounced on a slow tick), retries
// when the tuner does not answer, reports an outcome code and blocks
// transmit once the sequence has finished until the host drops its request.
module ext_tuner_ctrl #(
    parameter int TICK_DIV   = 48000,
    parameter int DELAY_T    = 100,
    parameter int PULSE_T    = 500,
    parameter int ACK_T      = 1000,
    parameter int TUNE_T     = 9000,
    parameter int GAP_T      = 200,
    parameter int RETRIES    = 2,
    parameter int DEB_T      = 3,
    parameter int STATUS_POL = 1,
    parameter int LEVEL_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_tune,
    input  logic       atu_status,
    input  logic       mox_in,
    output logic       atu_start,
    output logic       mox_out,
    output logic       busy,
    output logic [1:0] result,
    output logic [2:0] attempt
);

    localparam int             PW        = 17;
    localparam logic [PW-1:0]  PRE_LD    = PW'(TICK_DIV - 1);
    localparam logic [15:0]    DELAY_LD  = 16'(DELAY_T - 1);
    localparam logic [15:0]    PULSE_LD  = 16'(PULSE_T - 1);
    localparam logic [15:0]    ACK_LD    = 16'(ACK_T - 1);
    localparam logic [15:0]    TUNE_LD   = 16'(TUNE_T - 1);
    localparam logic [15:0]    GAP_LD    = 16'(GAP_T - 1);
    localparam logic [3:0]     DEB_LD    = 4'(DEB_T - 1);
    localparam logic [3:0]     RETRY_MAX = 4'(RETRIES);
    localparam logic           POL       = (STATUS_POL != 0);
    localparam logic           LVL       = (LEVEL_MODE != 0);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_OK      = 2'b01;
    localparam logic [1:0] RES_NOACK   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_WAIT_ACK,
        S_TUNING,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Tick fires while the counter sits at zero, so the first tick lands on
    // the first cycle after reset release.
    always_comb begin
        tick  = (pre_q == '0);
        pre_d = tick ? PRE_LD : (pre_q - PW'(1));
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    // ------------------------------------------------------------------
    // Status synchroniser and debounce
    // ------------------------------------------------------------------
    logic [1:0] sync_q, sync_d;
    logic       act;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic       st_q, st_d;

    // Two-flop shift of the raw asynchronous line; act is "tuner is tuning".
    always_comb begin
        sync_d = {sync_q[0], atu_status};
        act    = (sync_q[1] == POL);
    end

    // Synchroniser register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    // Accept a new status level only after DEB_T consecutive tick samples of it.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        st_d      = st_q;
        if (tick) begin
            if (act == st_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LD) begin
                st_d      = act;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            st_q      <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            st_q      <= st_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d, timer_dec;
    logic [3:0]  att_q, att_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        inhibit_q, inhibit_d;
    logic [1:0]  result_q, result_d;

    // Next-state logic; a dropped request overrides everything, on any cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        att_d     = att_q;
        start_d   = start_q;
        result_d  = result_q;
        timer_dec = timer_q - 16'd1;

        if (!auto_tune) begin
            state_d = S_IDLE;
            start_d = 1'b0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_DELAY;
                    timer_d  = DELAY_LD;
                    result_d = RES_NONE;
                    att_d    = '0;
                end
                S_DELAY: begin
                    if (timer_q == '0) begin
                        state_d = S_START;
                        timer_d = PULSE_LD;
                        att_d   = att_q + 4'd1;
                        start_d = 1'b1;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_START: begin
                    if (LVL) begin
                        // Level mode keeps start asserted into the ack wait.
                        state_d = S_WAIT_ACK;
                        timer_d = ACK_LD;
                    end else if (timer_q == '0) begin
                        state_d = S_WAIT_ACK;
                        timer_d = ACK_LD;
                        start_d = 1'b0;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_WAIT_ACK: begin
                    // An accepted status on the timeout tick still counts as ack.
                    if (st_q) begin
                        state_d = S_TUNING;
                        timer_d = TUNE_LD;
                        start_d = 1'b0;
                    end else if (timer_q == '0) begin
                        start_d = 1'b0;
                        if (att_q <= RETRY_MAX) begin
                            state_d = S_GAP;
                            timer_d = GAP_LD;
                        end else begin
                            state_d  = S_FAIL;
                            result_d = RES_NOACK;
                        end
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_GAP: begin
                    if (timer_q == '0) begin
                        state_d = S_START;
                        timer_d = PULSE_LD;
                        att_d   = att_q + 4'd1;
                        start_d = 1'b1;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_TUNING: begin
                    // Status released on the timeout tick is still a success.
                    if (!st_q) begin
                        state_d  = S_DONE;
                        result_d = RES_OK;
                    end else if (timer_q == '0) begin
                        state_d  = S_FAIL;
                        result_d = RES_TIMEOUT;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                default: begin
                    // DONE and FAIL wait for the host to drop the request.
                end
            endcase
        end

        busy_d    = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
        inhibit_d = (state_d inside {S_DONE, S_FAIL});
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            att_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            inhibit_q <= 1'b0;
            result_q  <= RES_NONE;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            att_q     <= att_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            inhibit_q <= inhibit_d;
            result_q  <= result_d;
        end
    end

    assign atu_start = start_q;
    assign busy      = busy_q;
    assign result    = result_q;
    // Up to RETRIES+1 = 8 attempts fit the internal count; the port saturates.
    assign attempt   = att_q[3] ? 3'd7 : att_q[2:0];
    assign mox_out   = mox_in & ~inhibit_q;

endmodule

// File: tb/tb_ext_tuner_ctrl.sv
// Directed bench for ext_tuner_ctrl: a pulse-mode, active-high instance and
// a level-mode, active-low instance share one clock.
module tb_ext_tuner_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1 = 1'b1, at1 = 1'b0, status1 = 1'b0, mi1 = 1'b1;
    logic start1, mo1, busy1;
    logic [1:0] res1;
    logic [2:0] att1;

    logic rst_n2 = 1'b1, at2 = 1'b0, status2 = 1'b1, mi2 = 1'b1;
    logic start2, mo2, busy2;
    logic [1:0] res2;
    logic [2:0] att2;

    ext_tuner_ctrl #(
        .TICK_DIV(4), .DELAY_T(2), .PULSE_T(3), .ACK_T(5), .TUNE_T(8),
        .GAP_T(2), .RETRIES(1), .DEB_T(2), .STATUS_POL(1), .LEVEL_MODE(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .auto_tune(at1), .atu_status(status1),
        .mox_in(mi1), .atu_start(start1), .mox_out(mo1), .busy(busy1),
        .result(res1), .attempt(att1)
    );

    ext_tuner_ctrl #(
        .TICK_DIV(4), .DELAY_T(2), .PULSE_T(3), .ACK_T(5), .TUNE_T(8),
        .GAP_T(2), .RETRIES(1), .DEB_T(2), .STATUS_POL(0), .LEVEL_MODE(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .auto_tune(at2), .atu_status(status2),
        .mox_in(mi2), .atu_start(start2), .mox_out(mo2), .busy(busy2),
        .result(res2), .attempt(att2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse monitors: count rises, last high width and last low gap (in clk).
    int rises1 = 0, w1 = 0, gap1 = 0, hi1 = 0, lo1 = 0;
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        if (start1 === 1'b1 && prev1 !== 1'b1) begin
            rises1 <= rises1 + 1; gap1 <= lo1; hi1 <= 1;
        end else if (start1 === 1'b1) begin
            hi1 <= hi1 + 1;
        end else if (prev1 === 1'b1) begin
            w1 <= hi1; lo1 <= 1;
        end else begin
            lo1 <= lo1 + 1;
        end
        prev1 <= start1;
    end

    int w2 = 0, hi2 = 0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        if (start2 === 1'b1 && prev2 !== 1'b1) hi2 <= 1;
        else if (start2 === 1'b1)              hi2 <= hi2 + 1;
        else if (prev2 === 1'b1)               w2 <= hi2;
        prev2 <= start2;
    end

    function automatic logic pick(input int s);
        case (s)
            0:       return start1;
            1:       return busy1;
            2:       return start2;
            default: return busy2;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic lvl, input int lim, input string tag);
        int n = 0;
        while (pick(s) !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (pick(s) !== lvl) chk(tag, 32'(pick(s)), 32'(lvl));
    endtask

    int r0;
    int n;

    initial begin
        #2;
        rst_n1 = 1'b0;
        rst_n2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n1 = 1'b1;
        rst_n2 = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_start", 32'(start1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_result", 32'(res1), 0);
        chk("rst_attempt", 32'(att1), 0);
        chk("rst_mox", 32'(mo1), 1);
        chk("rst_busy2", 32'(busy2), 0);
        repeat (4) @(negedge clk);

        // Normal tune
        r0  = rises1;
        at1 = 1'b1;
        wait_for(0, 1'b1, 100, "norm_rise_timeout");
        chk("norm_attempt_at_rise", 32'(att1), 1);
        chk("norm_busy", 32'(busy1), 1);
        wait_for(0, 1'b0, 100, "norm_fall_timeout");
        repeat (8) @(negedge clk);
        status1 = 1'b1;
        repeat (16) @(negedge clk);
        status1 = 1'b0;
        wait_for(1, 1'b0, 300, "norm_done_timeout");
        chk("norm_result", 32'(res1), 1);
        chk("norm_attempt", 32'(att1), 1);
        chk("norm_mox_inhibit", 32'(mo1), 0);
        chk("norm_width", 32'(w1), 12);
        chk("norm_pulses", 32'(rises1 - r0), 1);

        // Drop request from DONE: inhibit clears, outcome stays readable
        at1 = 1'b0;
        @(negedge clk);
        chk("abort_done_mox", 32'(mo1), 1);
        chk("abort_done_result", 32'(res1), 1);
        chk("abort_done_busy", 32'(busy1), 0);

        // No ack: two pulses, then FAIL with 10
        r0  = rises1;
        at1 = 1'b1;
        wait_for(1, 1'b1, 20, "noack_busy_timeout");
        wait_for(1, 1'b0, 500, "noack_end_timeout");
        chk("noack_result", 32'(res1), 2);
        chk("noack_attempt", 32'(att1), 2);
        chk("noack_pulses", 32'(rises1 - r0), 2);
        chk("noack_gap", 32'(gap1), 28);
        chk("noack_width", 32'(w1), 12);
        chk("noack_mox", 32'(mo1), 0);
        at1 = 1'b0;
        @(negedge clk);

        // Stuck tuner: status high right after the first pulse
        r0  = rises1;
        at1 = 1'b1;
        wait_for(0, 1'b1, 100, "stuck_rise_timeout");
        wait_for(0, 1'b0, 100, "stuck_fall_timeout");
        status1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy1 === 1'b1 && n < 500);
        chk("stuck_fall_to_fail_clk", 32'(n), 44);
        chk("stuck_result", 32'(res1), 3);
        chk("stuck_attempt", 32'(att1), 1);
        chk("stuck_pulses", 32'(rises1 - r0), 1);
        at1     = 1'b0;
        status1 = 1'b0;
        repeat (16) @(negedge clk);

        // Glitch rejection: one-tick status pulse during the ack wait
        r0  = rises1;
        at1 = 1'b1;
        wait_for(0, 1'b1, 100, "glitch_rise_timeout");
        wait_for(0, 1'b0, 100, "glitch_fall_timeout");
        repeat (4) @(negedge clk);
        status1 = 1'b1;
        repeat (4) @(negedge clk);
        status1 = 1'b0;
        wait_for(1, 1'b0, 500, "glitch_end_timeout");
        chk("glitch_result", 32'(res1), 2);
        chk("glitch_attempt", 32'(att1), 2);
        chk("glitch_pulses", 32'(rises1 - r0), 2);
        at1 = 1'b0;
        @(negedge clk);

        // Abort mid-pulse
        at1 = 1'b1;
        wait_for(0, 1'b1, 100, "abort_rise_timeout");
        repeat (4) @(negedge clk);
        at1 = 1'b0;
        @(negedge clk);
        chk("abort_start", 32'(start1), 0);
        chk("abort_busy", 32'(busy1), 0);
        chk("abort_mox", 32'(mo1), 1);
        chk("abort_result", 32'(res1), 0);
        chk("abort_attempt", 32'(att1), 1);
        at1 = 1'b1;
        wait_for(0, 1'b1, 100, "rereq_rise_timeout");
        chk("rereq_attempt", 32'(att1), 1);
        chk("rereq_result", 32'(res1), 0);

        // Asynchronous reset while start is high
        repeat (2) @(negedge clk);
        #1 rst_n1 = 1'b0;
        #1;
        chk("arst_start", 32'(start1), 0);
        chk("arst_busy", 32'(busy1), 0);
        chk("arst_attempt", 32'(att1), 0);
        at1 = 1'b0;
        @(negedge clk);
        rst_n1 = 1'b1;

        // Level mode, active-low status
        at2 = 1'b1;
        wait_for(2, 1'b1, 100, "lvl_rise_timeout");
        repeat (12) @(negedge clk);
        status2 = 1'b0;
        wait_for(2, 1'b0, 100, "lvl_fall_timeout");
        @(negedge clk);
        chk("lvl_width", 32'(w2), 24);
        chk("lvl_busy_tuning", 32'(busy2), 1);
        chk("lvl_attempt", 32'(att2), 1);
        chk("lvl_result", 32'(res2), 0);

        // Asynchronous reset mid-TUNING
        #2 rst_n2 = 1'b0;
        #1;
        chk("arst2_busy", 32'(busy2), 0);
        chk("arst2_start", 32'(start2), 0);
        chk("arst2_result", 32'(res2), 0);
        chk("arst2_attempt", 32'(att2), 0);
        chk("arst2_mox", 32'(mo2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
